// File: rtl/qsm_dim_sequencer.sv
// qsm_dim_sequencer
//   Sequences one QSPI DIM line: turns control pulses into RESET/READ frame
//   requests for the QSPI frame engine, paces consecutive READ frames, writes
//   every accepted returned word into the readout SRAM and keeps the status
//   fields for the register bank.
//
// Ports
//   clk_i, rst_n_i         clock, synchronous active-low reset
//   ctrl_reset_i/trig_i    1-cycle control pulses (RESET frame / readout)
//   last_reg_adr_i,
//   max_dim_no_i,
//   read_delay_i           configuration, shadowed when a command is accepted
//   busy_o, done_o,
//   err_many_o, err_fb_o,
//   dim_count_o            status
//   frm_start_o/type_o/
//   reg_o                  frame request to the QSPI engine
//   frm_word_valid_i/
//   word_i/done_i/
//   fb_err_i               frame engine results
//   mem_we_o/addr_o/data_o readout SRAM write port
module qsm_dim_sequencer #(
    parameter int CLK_PER_US = 40,
    parameter int TIMEOUT_US = 1000,
    parameter int MEM_AW     = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ctrl_reset_i,
    input  logic              ctrl_trig_i,
    input  logic [3:0]        last_reg_adr_i,
    input  logic [3:0]        max_dim_no_i,
    input  logic [9:0]        read_delay_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_many_o,
    output logic              err_fb_o,
    output logic [3:0]        dim_count_o,
    output logic              frm_start_o,
    output logic              frm_type_o,
    output logic [3:0]        frm_reg_o,
    input  logic              frm_word_valid_i,
    input  logic [15:0]       frm_word_i,
    input  logic              frm_done_i,
    input  logic              frm_fb_err_i,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [15:0]       mem_data_o
);

    localparam int DLY_MAX = 1023 * CLK_PER_US;
    localparam int DLY_W   = ($clog2(DLY_MAX + 1) > 16) ? $clog2(DLY_MAX + 1) : 16;
    localparam int TMO_CYC = TIMEOUT_US * CLK_PER_US;
    localparam int TMO_W   = $clog2(TMO_CYC + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST_REQ  = 3'd1;
    localparam logic [2:0] S_RST_WAIT = 3'd2;
    localparam logic [2:0] S_RD_REQ   = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_DELAY    = 3'd5;

    logic [2:0]        state;
    logic [3:0]        reg_idx;
    logic [3:0]        dev_idx;
    logic [3:0]        last_reg_q;
    logic [3:0]        max_dim_q;
    logic [9:0]        read_delay_q;
    logic [DLY_W-1:0]  dly_cnt;
    logic [DLY_W-1:0]  dly_cycles;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              mem_we_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [15:0]       mem_data_q;
    logic              done_q;
    logic              err_many_q;
    logic              err_fb_q;
    logic [3:0]        dim_count_q;

    logic              word_ok;
    logic [3:0]        dev_next;
    logic [3:0]        cnt_now;
    logic              many_now;
    logic              fb_now;

    assign dly_cycles = DLY_W'(read_delay_q) * DLY_W'(CLK_PER_US);

    // tmo_cnt holds the number of cycles since frm_start_o, so the abort
    // becomes visible exactly TMO_CYC cycles after the request.
    assign tmo_hit  = (tmo_cnt == TMO_W'(TMO_CYC - 1));

    assign word_ok  = (dev_idx < max_dim_q);
    assign dev_next = (dev_idx == 4'd15) ? 4'd15 : dev_idx + 4'd1;
    // A word arriving together with frm_done_i is counted before the frame closes.
    assign cnt_now  = frm_word_valid_i ? dev_next : dev_idx;
    assign many_now = err_many_q | (frm_word_valid_i & ~word_ok);
    assign fb_now   = err_fb_q | frm_fb_err_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= S_IDLE;
            reg_idx      <= 4'd0;
            dev_idx      <= 4'd0;
            last_reg_q   <= 4'd0;
            max_dim_q    <= 4'd0;
            read_delay_q <= 10'd0;
            dly_cnt      <= '0;
            tmo_cnt      <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= 16'd0;
            done_q       <= 1'b0;
            err_many_q   <= 1'b0;
            err_fb_q     <= 1'b0;
            dim_count_q  <= 4'd0;
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Reset has priority; a simultaneous trig is dropped.
                    if (ctrl_reset_i || ctrl_trig_i) begin
                        done_q       <= 1'b0;
                        err_many_q   <= 1'b0;
                        err_fb_q     <= 1'b0;
                        dim_count_q  <= 4'd0;
                        last_reg_q   <= last_reg_adr_i;
                        max_dim_q    <= max_dim_no_i;
                        read_delay_q <= read_delay_i;
                        reg_idx      <= 4'd0;
                        state        <= ctrl_reset_i ? S_RST_REQ : S_RD_REQ;
                    end
                end
                S_RST_REQ: begin
                    tmo_cnt <= TMO_W'(1);
                    state   <= S_RST_WAIT;
                end
                S_RST_WAIT: begin
                    if (frm_done_i) begin
                        err_fb_q <= fb_now;
                        state    <= S_IDLE;
                    end else if (tmo_hit) begin
                        err_fb_q <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_RD_REQ: begin
                    dev_idx <= 4'd0;
                    tmo_cnt <= TMO_W'(1);
                    state   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (frm_word_valid_i) begin
                        if (word_ok) begin
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= MEM_AW'({reg_idx, dev_idx});
                            mem_data_q <= frm_word_i;
                        end else begin
                            err_many_q <= 1'b1;
                        end
                        dev_idx <= dev_next;
                    end
                    if (frm_done_i) begin
                        if (reg_idx == 4'd0)
                            dim_count_q <= cnt_now;
                        err_fb_q <= fb_now;
                        if (many_now || fb_now) begin
                            state <= S_IDLE;
                        end else if (reg_idx == last_reg_q) begin
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            reg_idx <= reg_idx + 4'd1;
                            // Delays of 0 or 1 cycle both mean "request right after done".
                            if (dly_cycles <= DLY_W'(1)) begin
                                state <= S_RD_REQ;
                            end else begin
                                dly_cnt <= dly_cycles - DLY_W'(1);
                                state   <= S_DELAY;
                            end
                        end
                    end else if (tmo_hit) begin
                        err_fb_q <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_DELAY: begin
                    if (dly_cnt <= DLY_W'(1))
                        state <= S_RD_REQ;
                    else
                        dly_cnt <= dly_cnt - DLY_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = (state != S_IDLE);
    assign frm_start_o = (state == S_RST_REQ) || (state == S_RD_REQ);
    assign frm_type_o  = (state == S_RST_REQ);
    assign frm_reg_o   = (state == S_RD_REQ) ? reg_idx : 4'd0;
    assign done_o      = done_q;
    assign err_many_o  = err_many_q;
    assign err_fb_o    = err_fb_q;
    assign dim_count_o = dim_count_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;

endmodule
